// File: rtl/bcd_pkg.sv
// Shared constants and FSM state encoding for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADD3_THRESH = 5;
  localparam int ADJUST      = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/done handshake and result bus between a requester (master) and the converter (slave).
interface bin_to_bcd_seq_if
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) ();

  logic                            start;
  logic [BIN_W-1:0]                bin_in;
  logic                            busy;
  logic                            done;
  logic [DIGITS*BCD_DIGIT_W-1:0]   bcd_out;
  logic                            ovf;
  logic [DIGITS-1:0]               blank_n;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, ovf, blank_n
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, ovf, blank_n
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the next shift.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);

  // Inputs stay in 0..9, so d+3 tops out at 12 and never wraps the nibble.
  assign q = (d >= BCD_DIGIT_W'(ADD3_THRESH)) ? d + BCD_DIGIT_W'(ADJUST) : d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Multi-cycle double-dabble converter, one input bit per clock, start/done handshake.
// Define BIN_TO_BCD_BLANK_EN to generate leading-zero blanking on blank_n.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  bin_to_bcd_seq_if.slave   bus
);

  localparam int BCD_W = DIGITS * BCD_DIGIT_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  bcd_state_t       state_q, state_d;
  logic             load, shift_en;
  logic [CNT_W-1:0] cnt;
  logic [BIN_W-1:0] sh;
  logic [BCD_W-1:0] scratch, adj, scratch_nxt;
  logic             acc, acc_nxt;
  logic [BCD_W-1:0] bcd_q;
  logic             ovf_q;

  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (scratch[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .q (adj[k*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Adjusted digits shift left by one; the next binary bit enters digit 0.
  assign scratch_nxt = {adj[BCD_W-2:0], sh[BIN_W-1]};
  assign acc_nxt     = acc | adj[BCD_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Results are captured on the last shift so they are already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      sh      <= '0;
      scratch <= '0;
      acc     <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (load) begin
      cnt     <= CNT_W'(BIN_W - 1);
      sh      <= bus.bin_in;
      scratch <= '0;
      acc     <= 1'b0;
    end else if (shift_en) begin
      sh      <= {sh[BIN_W-2:0], 1'b0};
      scratch <= scratch_nxt;
      acc     <= acc_nxt;
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        bcd_q <= scratch_nxt;
        ovf_q <= acc_nxt;
      end
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.bcd_out = bcd_q;
  assign bus.ovf     = ovf_q;

`ifdef BIN_TO_BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q;

  // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] v, input logic o);
    logic [DIGITS-1:0] m;
    logic              any;
    any = 1'b0;
    m   = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      any  = any | (|v[k*BCD_DIGIT_W +: BCD_DIGIT_W]);
      m[k] = any | o;
    end
    m[0] = 1'b1;
    return m;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    blank_q <= '1;
    else if (shift_en && cnt == '0) blank_q <= blank_mask(scratch_nxt, acc_nxt);
  end

  assign bus.blank_n = blank_q;
`else
  assign bus.blank_n = '1;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq in three configurations (16/5, 8/3, 16/4).
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.BIN_W(16), .DIGITS(5)) ia ();
  bin_to_bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) ib ();
  bin_to_bcd_seq_if #(.BIN_W(16), .DIGITS(4)) ic ();

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  bin_to_bcd_seq #(.BIN_W(8),  .DIGITS(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));

`ifdef BIN_TO_BCD_BLANK_EN
  localparam logic [4:0] BL42 = 5'b00011;
  localparam logic [4:0] BL0  = 5'b00001;
`else
  localparam logic [4:0] BL42 = 5'b11111;
  localparam logic [4:0] BL0  = 5'b11111;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each conversion task returns the cycle on which done appeared (-1 on timeout)
  // and ends one cycle after done, back in idle.
  task automatic conv_a(input logic [15:0] v, output int lat, output int bcnt);
    ia.start = 1'b1; ia.bin_in = v; lat = -1; bcnt = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      ia.start = 1'b0;
      if (ia.busy) bcnt++;
      if (ia.done) begin lat = i; break; end
    end
    step();
  endtask

  task automatic conv_b(input logic [7:0] v, output int lat);
    ib.start = 1'b1; ib.bin_in = v; lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      ib.start = 1'b0;
      if (ib.done) begin lat = i; break; end
    end
    step();
  endtask

  task automatic conv_c(input logic [15:0] v, output int lat);
    ic.start = 1'b1; ic.bin_in = v; lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      ic.start = 1'b0;
      if (ic.done) begin lat = i; break; end
    end
    step();
  endtask

  initial begin
    int          lat, bcnt, ndone;
    logic [19:0] got;

    rst_n = 1'b0;
    ia.start = 1'b0; ia.bin_in = '0;
    ib.start = 1'b0; ib.bin_in = '0;
    ic.start = 1'b0; ic.bin_in = '0;
    step(); step();
    chk("rst_busy",  64'(ia.busy),    64'd0);
    chk("rst_done",  64'(ia.done),    64'd0);
    chk("rst_bcd",   64'(ia.bcd_out), 64'd0);
    chk("rst_ovf",   64'(ia.ovf),     64'd0);
    chk("rst_blank", 64'(ia.blank_n), 64'h1f);
    rst_n = 1'b1;
    step();

    // Full-scale 16-bit value
    conv_a(16'd65535, lat, bcnt);
    chk("a65535_lat",   64'(lat),        64'd17);
    chk("a65535_busy",  64'(bcnt),       64'd17);
    chk("a65535_idle",  64'(ia.busy),    64'd0);
    chk("a65535_bcd",   64'(ia.bcd_out), 64'h65535);
    chk("a65535_ovf",   64'(ia.ovf),     64'd0);
    chk("a65535_blank", 64'(ia.blank_n), 64'h1f);

    // 8-bit, 3-digit configuration
    conv_b(8'd255, lat);
    chk("b255_lat", 64'(lat),        64'd9);
    chk("b255_bcd", 64'(ib.bcd_out), 64'h255);
    conv_b(8'd0, lat);
    chk("b0_bcd",   64'(ib.bcd_out), 64'h000);
    chk("b0_ovf",   64'(ib.ovf),     64'd0);
    conv_b(8'd9, lat);
    chk("b9_bcd",   64'(ib.bcd_out), 64'h009);

    // 4 digits cannot hold 12345
    conv_c(16'd12345, lat);
    chk("c12345_lat", 64'(lat),        64'd17);
    chk("c12345_ovf", 64'(ic.ovf),     64'd1);
    chk("c12345_bcd", 64'(ic.bcd_out), 64'h2345);
    conv_c(16'd9999, lat);
    chk("c9999_ovf",  64'(ic.ovf),     64'd0);
    chk("c9999_bcd",  64'(ic.bcd_out), 64'h9999);

    // start while busy (mid-shift and in the done cycle) must be ignored
    ia.start = 1'b1; ia.bin_in = 16'd500; ndone = 0; got = '0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (ia.done) begin ndone++; got = ia.bcd_out; end
      ia.start  = (i == 5) || (i == 17);
      ia.bin_in = (i == 5) ? 16'd777 : ((i == 17) ? 16'd888 : 16'd500);
    end
    ia.start = 1'b0;
    chk("ign_ndone", 64'(ndone),   64'd1);
    chk("ign_bcd",   64'(got),     64'h00500);
    chk("ign_idle",  64'(ia.busy), 64'd0);
    conv_a(16'd321, lat, bcnt);
    chk("a321_bcd",  64'(ia.bcd_out), 64'h00321);

    // Reset in the middle of a conversion
    ia.start = 1'b1; ia.bin_in = 16'd1000;
    for (int i = 1; i <= 8; i++) begin
      step();
      ia.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 64'(ia.busy),    64'd0);
    chk("mrst_bcd",  64'(ia.bcd_out), 64'd0);
    chk("mrst_done", 64'(ia.done),    64'd0);
    step(); step();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 1; i <= 25; i++) begin
      step();
      if (ia.done) ndone++;
    end
    chk("mrst_nodone", 64'(ndone), 64'd0);

    conv_a(16'd42, lat, bcnt);
    chk("a42_bcd",   64'(ia.bcd_out), 64'h00042);
    chk("a42_blank", 64'(ia.blank_n), 64'(BL42));
    conv_a(16'd0, lat, bcnt);
    chk("a0_bcd",    64'(ia.bcd_out), 64'h00000);
    chk("a0_ovf",    64'(ia.ovf),     64'd0);
    chk("a0_blank",  64'(ia.blank_n), 64'(BL0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Parametrised, multi-cycle binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. Processes one input bit per clock, so the width is not limited by combinational depth. Uses a start/done handshake. Feeds the seven-segment display and score/readout paths where inputs are wider than 8 bits.

Parameters:
BIN_W, 16, width of the unsigned binary input (2..32)
DIGITS, 5, number of BCD digits produced; digit 0 = ones

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request conversion of bin_in; accepted only when busy=0
bin_in  in  BIN_W  unsigned value, sampled in the cycle start is accepted
busy  out  1  conversion in progress
done  out  1  single-cycle pulse: bcd_out/ovf valid
bcd_out  out  DIGITS*4  packed BCD, digit k at bits [4k+3:4k]
ovf  out  1  value exceeded DIGITS decimal digits; bcd_out holds the truncated low digits
blank_n  out  DIGITS  per-digit display enable (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, ovf=0, bcd_out=0, blank_n=all ones; internal shift register and counter cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start=1 latches bin_in into the shift register, clears the scratch BCD register and ovf accumulator, loads bit counter=BIN_W-1, then goes to SHIFT. busy=1 from the next cycle.
- SHIFT, one bit per cycle:
  - First, every scratch digit >=5 gets +3 (4-bit wrap impossible by construction).
  - Then {scratch, shift} is shifted left by 1; the MSB of shift enters digit 0 bit 0.
  - A 1 shifted out of the top digit's bit 3 sets the sticky ovf accumulator.
  - When counter=0, go to DONE; otherwise decrement the counter.
- DONE (one cycle): bcd_out and ovf registered from scratch/accumulator; done=1; busy=1. Return to IDLE next cycle, where busy=0.
- Latency: start accepted at cycle 0; done high at cycle BIN_W+1. Throughput is one conversion per BIN_W+2 cycles.
- bcd_out, ovf and blank_n hold their values between done pulses and change only in the DONE cycle.
- start while busy=1, including the DONE cycle: ignored, not queued. bin_in changes after acceptance have no effect.
- Reset mid-conversion: aborts immediately, no done pulse, outputs return to reset values.
- bin_in=0 gives bcd_out=0, ovf=0.
- Maximum bin_in (2^BIN_W-1) is converted correctly when DIGITS >= ceil(BIN_W*log10 2).

Optional Feature:
Macro BIN_TO_BCD_BLANK_EN.
- Defined: in the DONE cycle, blank_n[k]=0 for each leading-zero digit, i.e. digit k and all higher digits are 0. blank_n[0] is always 1, so a zero value shows a single "0". If ovf=1, all blank_n are 1.
- Undefined: blank_n tied to all ones; no blanking logic synthesised.

Decomposition:
- Shared package bcd_pkg:
  - BCD_DIGIT_W=4
  - ADD3_THRESH=5
  - ADJUST=3
  - state encoding typedef bcd_state_t {IDLE, SHIFT, DONE}
- Sub-module bcd_digit_adj: combinational 4-bit "if >=5 add 3", instantiated DIGITS times via generate.

Test Plan:
1. Defaults, start with bin_in=16'd65535 -> done at cycle 17; bcd_out=20'h65535, ovf=0, busy high for cycles 1..17.
2. BIN_W=8, DIGITS=3, bin_in=255 -> bcd_out=12'h255 after 9 cycles. Then bin_in=0 -> 12'h000; then bin_in=9 -> 12'h009.
3. BIN_W=16, DIGITS=4, bin_in=12345 -> ovf=1, bcd_out=16'h2345. Then bin_in=9999 -> ovf=0, bcd_out=16'h9999.
4. Start pulsed again at cycle 5 with a different bin_in -> ignored: a single done, with the result of the first value. Next start after busy falls -> converted normally.
5. rst_n low at cycle 8 of a conversion of 1000 -> no done; bcd_out=0, busy=0. A new start after reset with 42 -> 20'h00042.
6. With BIN_TO_BCD_BLANK_EN, defaults: 42 -> blank_n=5'b00011; 0 -> 5'b00001; 65535 -> 5'b11111. Without the macro -> blank_n=5'b11111 for all three.
